// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED PIO round-robin arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;
  localparam int unsigned LED_W         = 8;

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr.
module led_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               any,
  output logic [PTR_W-1:0]   idx
);

  int unsigned cand;

  // Scan offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    any  = |req;
    idx  = rr_ptr;
    cand = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = 32'(rr_ptr) + 32'(i);
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[PTR_W'(cand)]) idx = PTR_W'(cand);
    end
  end

endmodule

// File: rtl/led_pio_arbiter.sv
// Round-robin arbiter serialising LED writes from NUM_REQ requesters onto the PIO s1 port.
// Optional readback check of each write is enabled by defining LED_ARB_READBACK_EN.
module led_pio_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LED_W   = led_arb_pkg::LED_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     avm_chipselect,
  output logic                     avm_write_n,
  output logic [1:0]               avm_address,
  output logic [31:0]              avm_writedata,
  input  logic [31:0]              avm_readdata,
  output logic [LED_W-1:0]         led_shadow,
`ifdef LED_ARB_READBACK_EN
  output logic                     rb_err,
  input  logic                     rb_err_clr,
`endif
  output logic                     busy
);

  import led_arb_pkg::*;

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_next;
  logic [PTR_W-1:0]   sel, sel_next;
  logic [LED_W-1:0]   sel_data, sel_data_next;
  logic [PTR_W-1:0]   rr_ptr, rr_next;
  logic [NUM_REQ-1:0] gnt_next;
  logic               cs_next;
  logic               wn_next;
  logic [31:0]        wd_next;
  logic [LED_W-1:0]   shadow_next;
  logic               rb_set;
  logic               pick_any;
  logic [PTR_W-1:0]   pick_idx;
  logic               unused_rd;

  assign unused_rd = ^avm_readdata;

  led_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  // Next-state and next-output logic; bus outputs are registered from the next state.
  always_comb begin
    state_next    = state;
    sel_next      = sel;
    sel_data_next = sel_data;
    rr_next       = rr_ptr;
    gnt_next      = '0;
    cs_next       = 1'b0;
    wn_next       = 1'b1;
    wd_next       = avm_writedata;
    shadow_next   = led_shadow;
    rb_set        = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_next    = WRITE;
          sel_next      = pick_idx;
          sel_data_next = req_data[pick_idx*LED_W +: LED_W];
          cs_next       = 1'b1;
          wn_next       = 1'b0;
          wd_next       = 32'(req_data[pick_idx*LED_W +: LED_W]);
        end
      end
      WRITE: begin
        shadow_next = sel_data;
`ifdef LED_ARB_READBACK_EN
        state_next  = READ;
        cs_next     = 1'b1;
`else
        state_next  = DONE;
        gnt_next    = NUM_REQ'(1) << sel;
`endif
      end
      READ: begin
`ifdef LED_ARB_READBACK_EN
        rb_set = (avm_readdata[LED_W-1:0] != sel_data);
`endif
        state_next = DONE;
        gnt_next   = NUM_REQ'(1) << sel;
      end
      DONE: begin
        state_next = IDLE;
        rr_next    = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      sel            <= '0;
      sel_data       <= '0;
      rr_ptr         <= '0;
      gnt            <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= 2'd0;
      avm_writedata  <= '0;
      led_shadow     <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_next;
      sel            <= sel_next;
      sel_data       <= sel_data_next;
      rr_ptr         <= rr_next;
      gnt            <= gnt_next;
      avm_chipselect <= cs_next;
      avm_write_n    <= wn_next;
      avm_address    <= PIO_DATA_ADDR;
      avm_writedata  <= wd_next;
      led_shadow     <= shadow_next;
      busy           <= (state_next != IDLE);
    end
  end

`ifdef LED_ARB_READBACK_EN
  // Sticky readback error; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (reset) rb_err <= 1'b0;
    else       rb_err <= rb_set | (rb_err & ~rb_err_clr);
  end
`else
  logic unused_rb;
  assign unused_rb = rb_set;
`endif

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Scoreboard bench for led_pio_arbiter; readback checks run when LED_ARB_READBACK_EN is defined.
module tb_led_pio_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned LED_W   = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LED_W-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     avm_chipselect;
  logic                     avm_write_n;
  logic [1:0]               avm_address;
  logic [31:0]              avm_writedata;
  logic [31:0]              avm_readdata;
  logic [LED_W-1:0]         led_shadow;
  logic                     busy;
`ifdef LED_ARB_READBACK_EN
  logic                     rb_err;
  logic                     rb_err_clr;
`endif

  logic [7:0] pio_q;
  logic       force_bad;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]        exp_wr[$];
  logic [NUM_REQ-1:0] exp_gnt[$];

  always #5 clk = ~clk;

  led_pio_arbiter #(.NUM_REQ(NUM_REQ), .LED_W(LED_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_address    (avm_address),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .led_shadow     (led_shadow),
`ifdef LED_ARB_READBACK_EN
    .rb_err         (rb_err),
    .rb_err_clr     (rb_err_clr),
`endif
    .busy           (busy)
  );

  // Zero-wait-state PIO data register model.
  always_ff @(posedge clk) begin
    if (reset) pio_q <= 8'h00;
    else if (avm_chipselect && !avm_write_n && avm_address == 2'd0) pio_q <= avm_writedata[7:0];
  end
  assign avm_readdata = force_bad ? 32'h0 : {24'h0, pio_q};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every bus write and every grant must match the next expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (avm_chipselect && !avm_write_n) begin
        if (exp_wr.size() == 0) chk_eq("wr_unexpected", 32'(exp_wr.size()), 32'd1);
        else                    chk_eq("wr_data", avm_writedata, exp_wr.pop_front());
      end
      if (gnt != '0) begin
        if (exp_gnt.size() == 0) chk_eq("gnt_unexpected", 32'(exp_gnt.size()), 32'd1);
        else                     chk_eq("gnt_onehot", 32'(gnt), 32'(exp_gnt.pop_front()));
      end
    end
  end

  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*LED_W +: LED_W] = v;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [NUM_REQ-1:0] g);
    exp_wr.push_back({24'h0, d});
    exp_gnt.push_back(g);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk_eq({tag, "_gnt"},    32'(gnt),            32'd0);
    chk_eq({tag, "_cs"},     32'(avm_chipselect), 32'd0);
    chk_eq({tag, "_wn"},     32'(avm_write_n),    32'd1);
    chk_eq({tag, "_addr"},   32'(avm_address),    32'd0);
    chk_eq({tag, "_wdata"},  avm_writedata,       32'd0);
    chk_eq({tag, "_shadow"}, 32'(led_shadow),     32'd0);
    chk_eq({tag, "_busy"},   32'(busy),           32'd0);
  endtask

  // Requesters drop their bit on seeing gnt; returns once all served and idle.
  task automatic run_until_idle(input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      req = req & ~gnt;
      c++;
    end while ((req != '0 || busy) && c < budget);
    chk_eq("idle_reached", 32'(req != '0 || busy), 32'd0);
  endtask

  task automatic hold_grants(input int n, input int budget);
    int cnt;
    int last;
    cnt  = 0;
    last = 0;
    for (int c = 0; c < budget && cnt < n; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        cnt++;
        if (cnt > 1) chk_eq("gnt_spacing", 32'(c - last), 32'd3);
        last = c;
        if (cnt == n) req = '0;
      end
    end
    chk_eq("grant_count", 32'(cnt), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_data  = '0;
    force_bad = 1'b0;
`ifdef LED_ARB_READBACK_EN
    rb_err_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_reset_outs("in_reset");
    reset = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_reset_outs("idle");
    end

    // Single request, dropped and data changed after latch.
    req = 4'b0100;
    set_data(2, 8'hA5);
    push_exp(8'hA5, 4'b0100);
    @(negedge clk);
    chk_eq("write_cs",   32'(avm_chipselect), 32'd1);
    chk_eq("write_wn",   32'(avm_write_n),    32'd0);
    chk_eq("write_busy", 32'(busy),           32'd1);
    req = '0;
    set_data(2, 8'hFF);
    @(negedge clk);
    chk_eq("done_gnt",    32'(gnt),        32'h4);
    chk_eq("done_shadow", 32'(led_shadow), 32'hA5);
    @(negedge clk);
    chk_eq("idle_cs",    32'(avm_chipselect), 32'd0);
    chk_eq("idle_wn",    32'(avm_write_n),    32'd1);
    chk_eq("idle_wdata", avm_writedata,       32'hA5);
    chk_eq("idle_busy",  32'(busy),           32'd0);

    // Serve 3, then 0 and 3 together: pointer has wrapped to 0.
    req = 4'b1000;
    set_data(3, 8'h77);
    push_exp(8'h77, 4'b1000);
    run_until_idle(20);
    req = 4'b1001;
    set_data(0, 8'h55);
    set_data(3, 8'h66);
    push_exp(8'h55, 4'b0001);
    push_exp(8'h66, 4'b1000);
    run_until_idle(20);

    // All requesters held: 0,1,2,3,0 one write per 3 cycles.
    for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
    push_exp(8'h10, 4'b0001);
    push_exp(8'h11, 4'b0010);
    push_exp(8'h12, 4'b0100);
    push_exp(8'h13, 4'b1000);
    push_exp(8'h10, 4'b0001);
    req = 4'b1111;
    hold_grants(5, 40);
    run_until_idle(10);
    chk_eq("rr_shadow", 32'(led_shadow), 32'h10);

    // Move pointer to 2, then reset during a WRITE.
    req = 4'b0010;
    set_data(1, 8'h99);
    push_exp(8'h99, 4'b0010);
    run_until_idle(20);
    req = 4'b0100;
    set_data(2, 8'h42);
    exp_wr.push_back(32'h42);
    @(negedge clk);
    chk_eq("abort_in_write", 32'(avm_chipselect & ~avm_write_n), 32'd1);
    #1;
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    chk_reset_outs("abort");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("abort_no_gnt", 32'(gnt), 32'd0);
    end

    // Pointer back to 0 after reset: 1 wins over 3.
    req = 4'b1010;
    set_data(1, 8'hB1);
    set_data(3, 8'hB3);
    push_exp(8'hB1, 4'b0010);
    push_exp(8'hB3, 4'b1000);
    run_until_idle(20);

    // Identical values are written twice.
    for (int k = 0; k < 2; k++) begin
      req = 4'b0001;
      set_data(0, 8'h5A);
      push_exp(8'h5A, 4'b0001);
      run_until_idle(20);
    end

`ifdef LED_ARB_READBACK_EN
    // Bad readback sets sticky error; clear pulse and good readback keep it low.
    chk_eq("rb_err_init", 32'(rb_err), 32'd0);
    force_bad = 1'b1;
    req = 4'b0001;
    set_data(0, 8'h3C);
    push_exp(8'h3C, 4'b0001);
    run_until_idle(20);
    force_bad = 1'b0;
    chk_eq("rb_err_set", 32'(rb_err), 32'd1);
    repeat (3) @(negedge clk);
    chk_eq("rb_err_sticky", 32'(rb_err), 32'd1);
    rb_err_clr = 1'b1;
    @(negedge clk);
    rb_err_clr = 1'b0;
    chk_eq("rb_err_clr", 32'(rb_err), 32'd0);
    req = 4'b0010;
    set_data(1, 8'h3C);
    push_exp(8'h3C, 4'b0010);
    run_until_idle(20);
    chk_eq("rb_err_good", 32'(rb_err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk_eq("wr_queue_empty",  32'(exp_wr.size()),  32'd0);
    chk_eq("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
